int_ctrl_n: RTL and testbench
=============================

Name: int_ctrl_n

Overview:
- Parametrised interrupt controller for the MCU resource block; successor to the fixed 8-source, 2-output interrupt mask.
- Synchronises N_SRC external interrupt lines and applies per-source polarity, edge/level mode, mask and routing to INT0 (low priority) or INT1 (high priority).
- Registered INT0/INT1 outputs drive the core.
- Control and status registers are memory-mapped on the CPU data path, using the same RDN/WR0N/WR1N byte-strobe scheme as the rest of the MCU.

Parameters:
- N_SRC, 8, number of interrupt sources, 1..16.
- SYNC_STAGES, 2, synchroniser flops per source, 2..3.

Ports:
- CLK  input  1  system clock.
- RESETN  input  1  asynchronous active-low reset.
- SEL  input  1  chip select from address decoder.
- ADDR  input  3  register index.
- DIN  input  16  CPU write data.
- DOUT  output  16  read data; 0 unless SEL & !RDN.
- RDN  input  1  read strobe, active low.
- WR0N  input  1  low-byte write strobe, active low.
- WR1N  input  1  high-byte write strobe, active low.
- INTS  input  N_SRC  raw asynchronous interrupt sources.
- INT0  output  1  low-priority interrupt request to core.
- INT1  output  1  high-priority interrupt request to core.

Behaviour:
- Clocking and reset:
  - One clock, CLK.
  - Reset is asynchronous and active-low on RESETN. All flops clear on RESETN low.
  - INT0=0, INT1=0, all registers 0, DOUT=0.
- Register map (ADDR):
  - 0 PEND: read; write-1-to-clear.
  - 1 MASK: R/W; 1 = enabled.
  - 2 EDGE: R/W; 1 = edge mode, 0 = level mode.
  - 3 POL: R/W; 0 = active-high, 1 = active-low.
  - 4 ROUTE: R/W; 1 = source goes to INT1.
  - 5 VECTOR: read-only.
  - 6 SWSET: optional; see Optional Feature.
  - 7 CTRL: bit0 = GIE (global interrupt enable).
  - Bits at or above N_SRC read 0; writes to them are ignored.
- Writes:
  - Take effect at the rising CLK edge while SEL=1.
  - WR0N=0 writes bits 7:0; WR1N=0 writes bits 15:8. Both low writes all 16 bits.
  - Reads are combinational: DOUT = reg[ADDR] when SEL & !RDN, else 0.
- Synchroniser: SYNC_STAGES flops per source produce S[i]. A prev-stage flop P[i] holds S[i] delayed one cycle.
- Activity and edge detection:
  - active[i] = S[i] ^ POL[i].
  - Edge detect: rise[i] = active[i] & !(P[i] ^ POL[i]).
  - Changing POL while the input is steady produces no spurious edge.
- Edge mode:
  - PEND[i] sets on rise[i].
  - PEND[i] clears on a PEND write with a 1 in bit i.
  - If set and clear occur in the same cycle, set wins.
- Level mode:
  - PEND[i] <= active[i] every cycle; W1C has no effect.
  - A write that changes EDGE[i] from 0 to 1 clears PEND[i] in that cycle.
- Outputs:
  - req[i] = PEND[i] & MASK[i].
  - INT1 <= GIE & |(req & ROUTE); INT0 <= GIE & |(req & ~ROUTE). Both registered.
- Latency:
  - For an input held active, PEND is set SYNC_STAGES+1 clocks after the first sampling edge.
  - INT is asserted one clock after PEND.
  - A W1C of the only pending source drops INT on the second edge after the write edge.
- VECTOR:
  - bit15 = valid. bits 3:0 = lowest-numbered source with req & ROUTE.
  - If there is no such source, the lowest-numbered source with req & ~ROUTE.
  - If neither exists, VECTOR = 0.
  - VECTOR ignores GIE.
- MASK/GIE: clearing MASK or GIE does not clear PEND; pending edges persist.

Optional Feature:
- Macro: INT_CTRL_SWSET_EN.
- When defined:
  - Writing 1s to SWSET (address 6) sets the corresponding PEND bits for edge-mode sources only. Level-mode bits are ignored.
  - SWSET wins over a simultaneous W1C.
  - SWSET reads 0.
- When undefined: address 6 reads 0 and writes are ignored. There is no SWSET logic.

Decomposition:
- Register index constants (INTC_PEND..INTC_CTRL) and the GIE bit position go in the shared constants include.
- One sub-module, int_sync_edge: the SYNC_STAGES synchroniser, the P flop and the rise/active outputs for one source.
- int_sync_edge is instantiated N_SRC times in a generate loop.

Test Plan:
- Reset and default:
  - Stimulus: RESETN low mid-operation with PEND=0x0F and INT1=1.
  - Required: INT0=INT1=0 immediately, all registers 0, DOUT=0.
- Edge set and W1C:
  - Setup: N_SRC=8, EDGE=0x01, MASK=0x01, GIE=1.
  - Stimulus: pulse INTS[0] high for 1 clock, then write PEND=0x01.
  - Required: PEND=0x01 at SYNC_STAGES+1 clocks, INT0=1 one clock later; PEND=0 and INT0=0 after the write.
- Level and polarity:
  - Stimulus: EDGE=0, POL=0x04, MASK=0x04, ROUTE=0x04, INTS[2] held low; then drive it high; also toggle POL with the input steady.
  - Required: INT1=1 while low, 0 within SYNC_STAGES+2 clocks of going high; POL toggle causes no PEND glitch.
- Priority vector:
  - Stimulus: pend sources 5 (ROUTE=0) and 6 (ROUTE=1), both masked on.
  - Required: VECTOR=0x8006, INT0=INT1=1.
  - Then W1C source 6. Required: VECTOR=0x8005.
- Byte strobes and simultaneous events:
  - Stimulus: N_SRC=16; write MASK=0xFFFF with WR1N only, then W1C bit 9 in the same cycle as a new edge on source 9.
  - Required: MASK=0xFF00; PEND[9] remains 1.
- SWSET (INT_CTRL_SWSET_EN):
  - Stimulus: EDGE=0x03, write SWSET=0x07.
  - Required: PEND=0x03; SWSET reads 0; without the macro, PEND=0.

Source files
------------

// File: rtl/int_ctrl_n_pkg.sv
// int_ctrl_n_pkg: register indices and helpers shared by the interrupt controller
package int_ctrl_n_pkg;
  typedef enum logic [2:0] {
    INTC_PEND, INTC_MASK, INTC_EDGE, INTC_POL,
    INTC_ROUTE, INTC_VECTOR, INTC_SWSET, INTC_CTRL
  } intc_reg_e;
  localparam int GIE_BIT = 0;
  function automatic logic [15:0] wr_merge(input logic [15:0] q, input logic [15:0] d,
                                           input logic [15:0] m);
    return (q & ~m) | (d & m);
  endfunction
  function automatic logic [3:0] lsb_idx(input logic [15:0] v);
    lsb_idx = '0;
    for (int k = 15; k >= 0; k--) if (v[k]) lsb_idx = 4'(k);
  endfunction
endpackage

// File: rtl/int_sync_edge.sv
// int_sync_edge: per-source synchroniser, previous-sample flop, polarity-adjusted active and rise
// ports: clk_i, rst_ni (async active-low), in_i raw source, pol_i (1 = active-low),
//        active_o synchronised active level, rise_o inactive->active transition
module int_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  input  logic pol_i,
  output logic active_o,
  output logic rise_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end
  // both samples use the current polarity, so a POL change on a steady input is not an edge
  assign active_o = sync_q[SYNC_STAGES-1] ^ pol_i;
  assign rise_o   = active_o & ~(prev_q ^ pol_i);
endmodule

// File: rtl/int_ctrl_n.sv
// int_ctrl_n: parametrised interrupt controller with polarity, edge/level, mask and INT0/INT1 routing
// ports: CLK, RESETN (async active-low), SEL/ADDR/DIN/DOUT/RDN/WR0N/WR1N CPU register bus,
//        INTS[N_SRC] raw sources, INT0 low-priority and INT1 high-priority registered requests
// option: INT_CTRL_SWSET_EN enables the software-set register at address 6
module int_ctrl_n
  import int_ctrl_n_pkg::*;
#(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             SEL,
  input  logic [2:0]       ADDR,
  input  logic [15:0]      DIN,
  output logic [15:0]      DOUT,
  input  logic             RDN,
  input  logic             WR0N,
  input  logic             WR1N,
  input  logic [N_SRC-1:0] INTS,
  output logic             INT0,
  output logic             INT1
);
  localparam logic [15:0] VLD = 16'((32'd1 << N_SRC) - 32'd1);
  logic [N_SRC-1:0] act, rise;
  logic [15:0] pend_q, pend_d, mask_q, mask_d, edg_q, edg_d, pol_q, pol_d, route_q, route_d;
  logic [15:0] bm, w1c, sw, act16, rise16, req, hi, lo, vec, rd;
  logic        gie_q, gie_d, int0_q, int1_q;
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i   (CLK),
      .rst_ni  (RESETN),
      .in_i    (INTS[i]),
      .pol_i   (pol_q[i]),
      .active_o(act[i]),
      .rise_o  (rise[i])
    );
  end
  assign act16  = 16'(act);
  assign rise16 = 16'(rise);
  // byte strobes gated by chip select; bits at or above N_SRC never write
  assign bm = SEL ? {{8{~WR1N}}, {8{~WR0N}}} & VLD : '0;
  always_comb begin
    mask_d  = ADDR == INTC_MASK  ? wr_merge(mask_q, DIN, bm)  : mask_q;
    edg_d   = ADDR == INTC_EDGE  ? wr_merge(edg_q, DIN, bm)   : edg_q;
    pol_d   = ADDR == INTC_POL   ? wr_merge(pol_q, DIN, bm)   : pol_q;
    route_d = ADDR == INTC_ROUTE ? wr_merge(route_q, DIN, bm) : route_q;
    gie_d   = ADDR == INTC_CTRL && bm[GIE_BIT] ? DIN[GIE_BIT] : gie_q;
    w1c     = ADDR == INTC_PEND ? DIN & bm : '0;
`ifdef INT_CTRL_SWSET_EN
    sw      = ADDR == INTC_SWSET ? DIN & bm & edg_q : '0;
`else
    sw      = '0;
`endif
    // edge bits: set (rise or software) beats W1C; level bits track active,
    // except a 0->1 EDGE write clears the bit in that cycle
    pend_d  = (edg_q & (rise16 | sw | (pend_q & ~w1c))) | (~edg_q & ~edg_d & act16);
  end
  assign req = pend_q & mask_q;
  assign hi  = req & route_q;
  assign lo  = req & ~route_q;
  assign vec = |hi ? {1'b1, 11'd0, lsb_idx(hi)} : |lo ? {1'b1, 11'd0, lsb_idx(lo)} : '0;
  always_comb begin
    case (ADDR)
      INTC_PEND:   rd = pend_q;
      INTC_MASK:   rd = mask_q;
      INTC_EDGE:   rd = edg_q;
      INTC_POL:    rd = pol_q;
      INTC_ROUTE:  rd = route_q;
      INTC_VECTOR: rd = vec;
      INTC_CTRL:   rd = 16'(gie_q);
      default:     rd = '0;
    endcase
  end
  assign DOUT = SEL && !RDN ? rd : '0;
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pend_q  <= '0;
      mask_q  <= '0;
      edg_q   <= '0;
      pol_q   <= '0;
      route_q <= '0;
      gie_q   <= 1'b0;
      int0_q  <= 1'b0;
      int1_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      edg_q   <= edg_d;
      pol_q   <= pol_d;
      route_q <= route_d;
      gie_q   <= gie_d;
      int0_q  <= gie_q & |lo;
      int1_q  <= gie_q & |hi;
    end
  end
  assign INT0 = int0_q;
  assign INT1 = int1_q;
endmodule

// File: tb/tb_int_ctrl_n.sv
// tb_int_ctrl_n: directed self-checking bench for int_ctrl_n (8- and 16-source instances)
module tb_int_ctrl_n;
  logic        clk = 1'b0, rst_n = 1'b0, sel = 1'b0, rdn = 1'b1, wr0n = 1'b1, wr1n = 1'b1;
  logic [2:0]  addr = '0;
  logic [15:0] din = '0, ints = '0, dout8, dout16, d8, d16;
  logic        i0_8, i1_8, i0_16, i1_16;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  int_ctrl_n #(.N_SRC(8), .SYNC_STAGES(2)) dut8 (
    .CLK(clk), .RESETN(rst_n), .SEL(sel), .ADDR(addr), .DIN(din), .DOUT(dout8),
    .RDN(rdn), .WR0N(wr0n), .WR1N(wr1n), .INTS(ints[7:0]), .INT0(i0_8), .INT1(i1_8));
  int_ctrl_n #(.N_SRC(16), .SYNC_STAGES(2)) dut16 (
    .CLK(clk), .RESETN(rst_n), .SEL(sel), .ADDR(addr), .DIN(din), .DOUT(dout16),
    .RDN(rdn), .WR0N(wr0n), .WR1N(wr1n), .INTS(ints), .INT0(i0_16), .INT1(i1_16));
  task automatic wr(input logic [2:0] a, input logic [15:0] d,
                    input logic lo = 1'b1, input logic hi = 1'b1);
    @(negedge clk);
    sel = 1'b1; addr = a; din = d; wr0n = ~lo; wr1n = ~hi;
    @(posedge clk);
    #1 sel = 1'b0; wr0n = 1'b1; wr1n = 1'b1;
  endtask
  task automatic rd(input logic [2:0] a);
    sel = 1'b1; rdn = 1'b0; addr = a;
    #1 d8 = dout8; d16 = dout16;
    sel = 1'b0; rdn = 1'b1;
  endtask
  task automatic do_reset();
    ints = '0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rd(3'd5);
    checks++; if (d8 !== 16'h0 || i0_8 !== 1'b0 || i1_8 !== 1'b0) begin failures++;
      $display("FAIL por_state vector=%h int0=%b int1=%b exp 0000/0/0", d8, i0_8, i1_8); end
    rst_n = 1'b1;
    wr(3'd2, 16'h000F); wr(3'd1, 16'h000F); wr(3'd4, 16'h000F); wr(3'd7, 16'h0001);
    @(negedge clk) ints[3:0] = 4'hF;
    @(negedge clk) ints[3:0] = 4'h0;
    repeat (4) @(negedge clk);
    rd(3'd0);
    checks++; if (d8 !== 16'h000F || i1_8 !== 1'b1) begin failures++;
      $display("FAIL pre_reset pend=%h int1=%b exp 000F/1", d8, i1_8); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (i0_8 !== 1'b0 || i1_8 !== 1'b0 || i1_16 !== 1'b0) begin failures++;
      $display("FAIL async_reset int0=%b int1=%b int1_16=%b exp 0", i0_8, i1_8, i1_16); end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      checks++; if (d8 !== 16'h0) begin failures++;
        $display("FAIL reset_reg addr=%0d got=%h exp=0000", a, d8); end
    end
    @(negedge clk) rst_n = 1'b1;
  endtask
  task automatic test_edge_w1c();
    do_reset();
    wr(3'd2, 16'h0001); wr(3'd1, 16'h0001); wr(3'd7, 16'h0001);
    @(negedge clk) ints[0] = 1'b1;
    @(negedge clk) ints[0] = 1'b0;
    @(negedge clk) rd(3'd0);
    checks++; if (d8 !== 16'h0000) begin failures++;
      $display("FAIL edge_early pend=%h exp=0000", d8); end
    @(negedge clk) rd(3'd0);
    checks++; if (d8 !== 16'h0001 || i0_8 !== 1'b0) begin failures++;
      $display("FAIL edge_pend pend=%h int0=%b exp 0001/0", d8, i0_8); end
    @(negedge clk);
    checks++; if (i0_8 !== 1'b1 || i1_8 !== 1'b0) begin failures++;
      $display("FAIL edge_int int0=%b int1=%b exp 1/0", i0_8, i1_8); end
    wr(3'd0, 16'h0001);
    @(negedge clk) rd(3'd0);
    checks++; if (d8 !== 16'h0000) begin failures++;
      $display("FAIL w1c_pend pend=%h exp=0000", d8); end
    @(negedge clk);
    checks++; if (i0_8 !== 1'b0) begin failures++;
      $display("FAIL w1c_int int0=%b exp=0", i0_8); end
  endtask
  task automatic test_level_pol();
    do_reset();
    wr(3'd3, 16'h0004); wr(3'd1, 16'h0004); wr(3'd4, 16'h0004); wr(3'd7, 16'h0001);
    repeat (3) @(negedge clk);
    rd(3'd0);
    checks++; if (d8 !== 16'h0004 || i1_8 !== 1'b1 || i0_8 !== 1'b0) begin failures++;
      $display("FAIL level_low pend=%h int1=%b int0=%b exp 0004/1/0", d8, i1_8, i0_8); end
    @(negedge clk) ints[2] = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (i1_8 !== 1'b1) begin failures++;
      $display("FAIL level_hold int1=%b exp=1", i1_8); end
    repeat (2) @(negedge clk);
    checks++; if (i1_8 !== 1'b0) begin failures++;
      $display("FAIL level_drop int1=%b exp=0", i1_8); end
    wr(3'd2, 16'h0004);
    wr(3'd3, 16'h0000);
    repeat (3) @(negedge clk);
    rd(3'd0);
    checks++; if (d8 !== 16'h0000) begin failures++;
      $display("FAIL pol_toggle_a pend=%h exp=0000", d8); end
    wr(3'd3, 16'h0004);
    repeat (3) @(negedge clk);
    rd(3'd0);
    checks++; if (d8 !== 16'h0000 || i1_8 !== 1'b0) begin failures++;
      $display("FAIL pol_toggle_b pend=%h int1=%b exp 0000/0", d8, i1_8); end
  endtask
  task automatic test_vector();
    do_reset();
    wr(3'd2, 16'h0060); wr(3'd1, 16'h0060); wr(3'd4, 16'h0040); wr(3'd7, 16'h0001);
    @(negedge clk) ints[6:5] = 2'b11;
    @(negedge clk) ints[6:5] = 2'b00;
    repeat (4) @(negedge clk);
    rd(3'd5);
    checks++; if (d8 !== 16'h8006 || i0_8 !== 1'b1 || i1_8 !== 1'b1) begin failures++;
      $display("FAIL vector_hi vec=%h int0=%b int1=%b exp 8006/1/1", d8, i0_8, i1_8); end
    wr(3'd0, 16'h0040);
    @(negedge clk) rd(3'd5);
    checks++; if (d8 !== 16'h8005) begin failures++;
      $display("FAIL vector_lo vec=%h exp=8005", d8); end
    @(negedge clk);
    checks++; if (i1_8 !== 1'b0 || i0_8 !== 1'b1) begin failures++;
      $display("FAIL vector_ints int1=%b int0=%b exp 0/1", i1_8, i0_8); end
    wr(3'd7, 16'h0000);
    repeat (2) @(negedge clk);
    rd(3'd5);
    checks++; if (d8 !== 16'h8005 || i0_8 !== 1'b0) begin failures++;
      $display("FAIL gie_off vec=%h int0=%b exp 8005/0", d8, i0_8); end
    rd(3'd0);
    checks++; if (d8 !== 16'h0020) begin failures++;
      $display("FAIL gie_keeps_pend pend=%h exp=0020", d8); end
  endtask
  task automatic test_byte_strobes();
    do_reset();
    wr(3'd1, 16'hFFFF, 1'b0, 1'b1);
    @(negedge clk) rd(3'd1);
    checks++; if (d16 !== 16'hFF00 || d8 !== 16'h0000) begin failures++;
      $display("FAIL wr1n_only mask16=%h mask8=%h exp FF00/0000", d16, d8); end
    wr(3'd1, 16'hFFFF);
    @(negedge clk) rd(3'd1);
    checks++; if (d16 !== 16'hFFFF || d8 !== 16'h00FF) begin failures++;
      $display("FAIL width_clip mask16=%h mask8=%h exp FFFF/00FF", d16, d8); end
    sel = 1'b0; rdn = 1'b0; addr = 3'd1;
    #1 checks++; if (dout16 !== 16'h0000) begin failures++;
      $display("FAIL dout_gate dout=%h exp=0000", dout16); end
    rdn = 1'b1;
    wr(3'd2, 16'h0200);
    @(negedge clk) ints[9] = 1'b1;
    @(negedge clk) ints[9] = 1'b0;
    repeat (3) @(negedge clk);
    rd(3'd0);
    checks++; if (d16 !== 16'h0200) begin failures++;
      $display("FAIL src9_pend pend=%h exp=0200", d16); end
    @(negedge clk) ints[9] = 1'b1;
    @(negedge clk) ints[9] = 1'b0;
    wr(3'd0, 16'h0200);
    @(negedge clk) rd(3'd0);
    checks++; if (d16 !== 16'h0200) begin failures++;
      $display("FAIL set_beats_w1c pend=%h exp=0200", d16); end
    wr(3'd0, 16'h0200);
    @(negedge clk) rd(3'd0);
    checks++; if (d16 !== 16'h0000) begin failures++;
      $display("FAIL plain_w1c pend=%h exp=0000", d16); end
  endtask
  task automatic test_swset();
    logic [15:0] exp_pend;
`ifdef INT_CTRL_SWSET_EN
    exp_pend = 16'h0003;
`else
    exp_pend = 16'h0000;
`endif
    do_reset();
    wr(3'd2, 16'h0003);
    wr(3'd6, 16'h0007);
    @(negedge clk) rd(3'd0);
    checks++; if (d8 !== exp_pend) begin failures++;
      $display("FAIL swset_pend pend=%h exp=%h", d8, exp_pend); end
    rd(3'd6);
    checks++; if (d8 !== 16'h0000) begin failures++;
      $display("FAIL swset_read got=%h exp=0000", d8); end
  endtask
  initial begin
    test_reset();
    test_edge_w1c();
    test_level_pol();
    test_vector();
    test_byte_strobes();
    test_swset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
